// File: rtl/magcol_pkg.sv
// Shared definitions for the magnitude collector: lane geometry, the
// committed-word type and the saturating counter helper.
package magcol_pkg;

  localparam int LANES  = 8;
  localparam int MAG_W  = 16;
  localparam int WORD_W = LANES * MAG_W;

  typedef logic [WORD_W-1:0] mag_word_t;

  // Adds inc to cnt and clamps the result to the all-ones value of a
  // counter that is 'width' bits wide. Callers truncate the result.
  function automatic logic [63:0] sat_inc(input logic [63:0] cnt,
                                          input logic [63:0] inc,
                                          input int unsigned width);
    logic [63:0] max_v;
    logic [63:0] sum;
    max_v = (64'd1 << width) - 64'd1;
    sum   = cnt + inc;
    return (sum > max_v) ? max_v : sum;
  endfunction

endpackage

// File: rtl/magcol_fifo.sv
// First-word fall-through FIFO for committed sample sets. The head entry
// is presented combinationally from storage; it reads as zero when empty.
// A push while full is accepted only if a pop happens in the same cycle.
module magcol_fifo #(
  parameter int WIDTH   = 128,
  parameter int FIFO_AW = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  logic [WIDTH-1:0]   push_data_i,
  input  logic               pop_i,
  output logic [WIDTH-1:0]   head_data_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [FIFO_AW:0]   count_o
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q;
  logic [FIFO_AW-1:0] rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic               push_ok;
  logic               pop_ok;

  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == (FIFO_AW + 1)'(DEPTH));
  assign count_o     = count_q;
  assign pop_ok      = pop_i && !empty_o;
  assign push_ok     = push_i && (!full_o || pop_ok);
  assign head_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Storage write at the tail pointer.
  // NOTE: the storage array has no reset; pointers and count define which
  // entries are live, so resetting the array would only cost flops.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap modulo the depth.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (FIFO_AW + 1)'(1);
        2'b01:   count_q <= count_q - (FIFO_AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/magnitude_collector.sv
// Collects eight 16-bit magnitude lanes into one 128-bit AXI-Stream word
// per complete sample set, buffering committed words in a small FIFO.
// Counts words lost to a full FIFO and lanes that report twice before
// their set completes. Optional frame marking on m_axis_tlast is built
// when MAGCOL_TLAST_EN is defined.
module magnitude_collector
  import magcol_pkg::*;
#(
  parameter int FIFO_AW     = 3,
  parameter int FRAME_WORDS = 32,
  parameter int CNT_W       = 16
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [WORD_W-1:0]    s_mag_tdata,
  input  logic [LANES-1:0]     s_mag_tvalid,
  output logic [WORD_W-1:0]    m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
`ifdef MAGCOL_TLAST_EN
  output logic                 m_axis_tlast,
`endif
  output logic [CNT_W-1:0]     drop_count,
  output logic [CNT_W-1:0]     overrun_count,
  output logic [LANES-1:0]     lane_pending
);

  logic [MAG_W-1:0] hold_q [LANES];
  logic [MAG_W-1:0] hold_d [LANES];
  logic [LANES-1:0] flag_q;
  logic [LANES-1:0] flag_d;
  logic [CNT_W-1:0] drop_q;
  logic [CNT_W-1:0] drop_d;
  logic [CNT_W-1:0] ovr_q;
  logic [CNT_W-1:0] ovr_d;
  logic [3:0]       ovr_events;
  logic             commit;
  logic             drop;
  logic             pop;
  mag_word_t        commit_word;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FIFO_AW:0] fifo_count_unused;

  assign commit        = &(flag_q | s_mag_tvalid);
  assign m_axis_tvalid = !fifo_empty;
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign drop          = commit && fifo_full && !pop;
  assign lane_pending  = flag_q;
  assign drop_count    = drop_q;
  assign overrun_count = ovr_q;

  // Next-state for lane holding registers, flags, commit word and counters.
  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    commit_word = '0;
    for (int i = 0; i < LANES; i++) begin
      hold_d[i] = hold_q[i];
      if (s_mag_tvalid[i]) begin
        hold_d[i] = s_mag_tdata[i*MAG_W +: MAG_W];
      end
      commit_word[i*MAG_W +: MAG_W] = s_mag_tvalid[i] ? s_mag_tdata[i*MAG_W +: MAG_W]
                                                      : hold_q[i];
    end
    // Valids landing in the commit cycle are consumed by the commit.
    flag_d     = commit ? '0 : (flag_q | s_mag_tvalid);
    ovr_events = commit ? 4'd0 : 4'($countones(s_mag_tvalid & flag_q));
    ovr_d      = CNT_W'(sat_inc(64'(ovr_q), 64'(ovr_events), CNT_W));
    drop_d     = drop ? CNT_W'(sat_inc(64'(drop_q), 64'd1, CNT_W)) : drop_q;
  end

  // Collection state and loss/overrun counters.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < LANES; i++) hold_q[i] <= '0;
      flag_q <= '0;
      drop_q <= '0;
      ovr_q  <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) hold_q[i] <= hold_d[i];
      flag_q <= flag_d;
      drop_q <= drop_d;
      ovr_q  <= ovr_d;
    end
  end

  magcol_fifo #(
    .WIDTH   (WORD_W),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk         (aclk),
    .rst         (areset),
    .push_i      (commit),
    .push_data_i (commit_word),
    .pop_i       (pop),
    .head_data_o (m_axis_tdata),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count_unused)
  );

`ifdef MAGCOL_TLAST_EN
  localparam int WC_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  logic [WC_W-1:0] word_cnt_q;

  // Frame position follows popped words only, so drops never shift it.
  assign m_axis_tlast = m_axis_tvalid && (word_cnt_q == WC_W'(FRAME_WORDS - 1));

  // Popped-word counter; wraps after the word that carries tlast.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      word_cnt_q <= '0;
    end else if (pop) begin
      word_cnt_q <= m_axis_tlast ? '0 : word_cnt_q + WC_W'(1);
    end
  end
`else
  // Frame length only matters when tlast generation is built.
  logic unused_frame_words;
  assign unused_frame_words = (FRAME_WORDS > 0);
`endif

endmodule
